// File: rtl/pipe_probe_display.sv
// Debug probe display: pushbutton-selected probe channel, optional freeze,
// captured value decoded onto active-low seven-segment digits.
module pipe_probe_display #(
  parameter int DATA_WIDTH      = 16,
  parameter int DIGITS          = 4,
  parameter int CHANNELS        = 4,
  parameter int CH_W            = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                           I_CLOCK,
  input  logic                           I_RESET,
  input  logic                           I_LOCK,
  input  logic [CHANNELS*DATA_WIDTH-1:0] I_ProbeData,
  input  logic                           I_KeySelect_n,
  input  logic                           I_KeyFreeze_n,
  output logic [CH_W-1:0]                O_Channel,
  output logic                           O_Frozen,
  output logic [DATA_WIDTH-1:0]          O_Value,
  output logic [7*DIGITS-1:0]            O_HEX
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam int NKEYS = 2;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Key index 0 = select, 1 = freeze.
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_evt;

  assign key_raw = {I_KeyFreeze_n, I_KeySelect_n};

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             level_q, level_d;
      logic             evt_q, evt_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d = key_raw[gi];
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Only the press edge (released -> pressed) is an event.
        evt_d = level_q & ~level_d;
      end

      always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          level_q <= 1'b1;
          cnt_q   <= '0;
          evt_q   <= 1'b0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          level_q <= level_d;
          cnt_q   <= cnt_d;
          evt_q   <= evt_d;
        end
      end

      assign key_evt[gi] = evt_q;
    end
  endgenerate

  logic                  sel_evt, frz_evt;
  logic [CH_W-1:0]       channel_q, channel_d;
  logic                  frozen_q, frozen_d;
  logic                  reload_q, reload_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] probe_sel;
  logic [7*DIGITS-1:0]   hex_q, hex_d;

  assign sel_evt = key_evt[0];
  assign frz_evt = key_evt[1];

  always_comb begin
    probe_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (channel_q == CH_W'(c)) begin
        probe_sel = I_ProbeData[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    channel_d = channel_q;
    if (sel_evt) begin
      channel_d = (channel_q == CH_LAST) ? '0 : channel_q + 1'b1;
    end
    frozen_d = frozen_q ^ frz_evt;
    // Reload forces one sample of the newly selected channel even when frozen.
    reload_d = sel_evt;
    value_d  = value_q;
    if (I_LOCK & (~frozen_q | reload_q)) begin
      value_d = probe_sel;
    end
  end

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign hex_d[7*gi +: 7] = seg_decode(value_q[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      channel_q <= '0;
      frozen_q  <= 1'b0;
      reload_q  <= 1'b0;
      value_q   <= '0;
      hex_q     <= {DIGITS{7'h40}};
    end else begin
      channel_q <= channel_d;
      frozen_q  <= frozen_d;
      reload_q  <= reload_d;
      value_q   <= value_d;
      hex_q     <= hex_d;
    end
  end

  assign O_Channel = channel_q;
  assign O_Frozen  = frozen_q;
  assign O_Value   = value_q;
  assign O_HEX     = hex_q;

endmodule

// File: tb/tb_pipe_probe_display.sv
// Bench for pipe_probe_display: directed scenarios plus randomized key/probe
// traffic checked against a transaction-level model of channel/freeze/capture.
module tb_pipe_probe_display;

  localparam int DW = 16;
  localparam int DIG = 4;
  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int DEB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            lock;
  logic [NCH*DW-1:0] probe_bus;
  logic            key_sel_n, key_frz_n;
  logic [CHW-1:0]  o_ch;
  logic            o_frz;
  logic [DW-1:0]   o_val;
  logic [7*DIG-1:0] o_hex;

  logic [DW-1:0] probes [NCH];
  logic [6:0]    seg_tab [16];

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state
  int            m_ch;
  bit            m_frozen;
  logic [DW-1:0] m_value;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < NCH; c++) probe_bus[c*DW +: DW] = probes[c];
  end

  pipe_probe_display #(
    .DATA_WIDTH(DW), .DIGITS(DIG), .CHANNELS(NCH), .CH_W(CHW), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_ProbeData(probe_bus),
    .I_KeySelect_n(key_sel_n), .I_KeyFreeze_n(key_frz_n),
    .O_Channel(o_ch), .O_Frozen(o_frz), .O_Value(o_val), .O_HEX(o_hex)
  );

  function automatic logic [7*DIG-1:0] exp_hex(input logic [DW-1:0] v);
    logic [7*DIG-1:0] h;
    for (int d = 0; d < DIG; d++) h[7*d +: 7] = seg_tab[v[4*d +: 4]];
    return h;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Displayed value once everything has settled.
  task automatic model_settle();
    if (lock && !m_frozen) m_value = probes[m_ch];
  endtask

  task automatic model_press(input bit sel, input bit frz);
    if (sel) m_ch = (m_ch + 1) % NCH;
    if (frz) m_frozen = !m_frozen;
    if (lock && (sel || !m_frozen)) m_value = probes[m_ch];
  endtask

  task automatic press(input bit sel, input bit frz, input int hold);
    key_sel_n = !sel;
    key_frz_n = !frz;
    tick(hold);
    key_sel_n = 1'b1;
    key_frz_n = 1'b1;
    tick(12);
    model_press(sel, frz);
  endtask

  task automatic goto_ch0_unfrozen();
    if (m_frozen) press(1'b0, 1'b1, 10);
    while (m_ch != 0) press(1'b1, 1'b0, 10);
  endtask

  task automatic test_reset();
    probes[0] = 16'hA5A5; probes[1] = 16'h1234; probes[2] = 16'hBEEF;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_ch = 0; m_frozen = 0; m_value = '0;
    n_cmp += 4;
    if (o_val !== 16'h0) begin n_bad++; $display("FAIL reset_value got %h want 0000", o_val); end
    if (o_hex !== {DIG{7'h40}}) begin n_bad++; $display("FAIL reset_hex got %h want %h", o_hex, {DIG{7'h40}}); end
    if (o_ch !== 2'd0) begin n_bad++; $display("FAIL reset_channel got %0d want 0", o_ch); end
    if (o_frz !== 1'b0) begin n_bad++; $display("FAIL reset_frozen got %b want 0", o_frz); end
    tick(1);
    n_cmp += 2;
    if (o_val !== 16'hA5A5) begin n_bad++; $display("FAIL first_capture got %h want a5a5", o_val); end
    if (o_hex !== {DIG{7'h40}}) begin n_bad++; $display("FAIL hex_latency got %h want %h", o_hex, {DIG{7'h40}}); end
    tick(1);
    model_settle();
    n_cmp += 1;
    if (o_hex !== {7'h08, 7'h12, 7'h08, 7'h12}) begin n_bad++; $display("FAIL first_hex got %h want %h", o_hex, {7'h08, 7'h12, 7'h08, 7'h12}); end
    $display("txn reset: ch=%0d frozen=%b value=%h hex=%h", o_ch, o_frz, o_val, o_hex);
  endtask

  task automatic test_select();
    logic [DW-1:0] want_val [3];
    int want_ch [3];
    want_ch[0] = 1; want_ch[1] = 2; want_ch[2] = 0;
    want_val[0] = 16'h1234; want_val[1] = 16'hBEEF; want_val[2] = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 10);
      n_cmp += 3;
      if (o_ch !== CHW'(want_ch[i])) begin n_bad++; $display("FAIL select_ch[%0d] got %0d want %0d", i, o_ch, want_ch[i]); end
      if (o_val !== want_val[i]) begin n_bad++; $display("FAIL select_val[%0d] got %h want %h", i, o_val, want_val[i]); end
      if (o_hex !== exp_hex(want_val[i])) begin n_bad++; $display("FAIL select_hex[%0d] got %h want %h", i, o_hex, exp_hex(want_val[i])); end
      $display("txn select %0d: ch=%0d value=%h", i, o_ch, o_val);
    end
  endtask

  task automatic test_glitch_and_hold();
    key_sel_n = 1'b0;
    tick(3);
    key_sel_n = 1'b1;
    tick(15);
    n_cmp += 1;
    if (o_ch !== CHW'(m_ch)) begin n_bad++; $display("FAIL glitch_ch got %0d want %0d", o_ch, m_ch); end
    $display("txn glitch: ch=%0d", o_ch);
    press(1'b1, 1'b0, 50);
    n_cmp += 2;
    if (o_ch !== CHW'(m_ch)) begin n_bad++; $display("FAIL long_hold_ch got %0d want %0d", o_ch, m_ch); end
    if (o_val !== m_value) begin n_bad++; $display("FAIL long_hold_val got %h want %h", o_val, m_value); end
    $display("txn long hold: ch=%0d value=%h", o_ch, o_val);
  endtask

  task automatic test_freeze();
    goto_ch0_unfrozen();
    press(1'b0, 1'b1, 10);
    probes[0] = 16'h0000;
    tick(4);
    n_cmp += 2;
    if (o_frz !== 1'b1) begin n_bad++; $display("FAIL freeze_flag got %b want 1", o_frz); end
    if (o_val !== 16'hA5A5) begin n_bad++; $display("FAIL freeze_hold got %h want a5a5", o_val); end
    press(1'b1, 1'b0, 10);
    n_cmp += 1;
    if (o_val !== 16'h1234) begin n_bad++; $display("FAIL frozen_reload got %h want 1234", o_val); end
    probes[1] = 16'h9999;
    tick(4);
    n_cmp += 2;
    if (o_val !== 16'h1234) begin n_bad++; $display("FAIL frozen_after_reload got %h want 1234", o_val); end
    if (o_hex !== exp_hex(16'h1234)) begin n_bad++; $display("FAIL frozen_hex got %h want %h", o_hex, exp_hex(16'h1234)); end
    $display("txn freeze: ch=%0d frozen=%b value=%h", o_ch, o_frz, o_val);
    press(1'b0, 1'b1, 10);
    n_cmp += 2;
    if (o_frz !== 1'b0) begin n_bad++; $display("FAIL unfreeze_flag got %b want 0", o_frz); end
    if (o_val !== 16'h9999) begin n_bad++; $display("FAIL unfreeze_val got %h want 9999", o_val); end
    $display("txn unfreeze: value=%h", o_val);
  endtask

  task automatic test_both_keys();
    probes[0] = 16'hA5A5; probes[1] = 16'h1234;
    goto_ch0_unfrozen();
    press(1'b1, 1'b1, 10);
    n_cmp += 3;
    if (o_ch !== 2'd1) begin n_bad++; $display("FAIL both_ch got %0d want 1", o_ch); end
    if (o_frz !== 1'b1) begin n_bad++; $display("FAIL both_frozen got %b want 1", o_frz); end
    if (o_val !== 16'h1234) begin n_bad++; $display("FAIL both_val got %h want 1234", o_val); end
    probes[1] = 16'h5555;
    tick(5);
    n_cmp += 1;
    if (o_val !== 16'h1234) begin n_bad++; $display("FAIL both_hold got %h want 1234", o_val); end
    $display("txn both keys: ch=%0d frozen=%b value=%h", o_ch, o_frz, o_val);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          probes[$urandom_range(0, NCH - 1)] = DW'($urandom);
          tick(3);
          model_settle();
        end
        1: press(1'b1, 1'b0, $urandom_range(6, 14));
        2: press(1'b0, 1'b1, $urandom_range(6, 14));
        default: begin
          if ($urandom_range(0, 1) == 1) key_sel_n = 1'b0; else key_frz_n = 1'b0;
          tick($urandom_range(1, 3));
          key_sel_n = 1'b1; key_frz_n = 1'b1;
          tick(10);
        end
      endcase
      n_cmp += 4;
      if (o_ch !== CHW'(m_ch)) begin n_bad++; $display("FAIL rand_ch[%0d] got %0d want %0d", t, o_ch, m_ch); end
      if (o_frz !== m_frozen) begin n_bad++; $display("FAIL rand_frozen[%0d] got %b want %b", t, o_frz, m_frozen); end
      if (o_val !== m_value) begin n_bad++; $display("FAIL rand_val[%0d] got %h want %h", t, o_val, m_value); end
      if (o_hex !== exp_hex(m_value)) begin n_bad++; $display("FAIL rand_hex[%0d] got %h want %h", t, o_hex, exp_hex(m_value)); end
      $display("txn random %0d op=%0d: ch=%0d frozen=%b value=%h", t, op, o_ch, o_frz, o_val);
    end
  endtask

  task automatic test_lock();
    logic [DW-1:0] held;
    goto_ch0_unfrozen();
    held = m_value;
    lock = 1'b0;
    for (int c = 0; c < NCH; c++) probes[c] = probes[c] ^ 16'hFFFF;
    tick(5);
    n_cmp += 2;
    if (o_val !== held) begin n_bad++; $display("FAIL nolock_val got %h want %h", o_val, held); end
    if (o_hex !== exp_hex(held)) begin n_bad++; $display("FAIL nolock_hex got %h want %h", o_hex, exp_hex(held)); end
    press(1'b1, 1'b0, 10);
    n_cmp += 2;
    if (o_ch !== CHW'(m_ch)) begin n_bad++; $display("FAIL nolock_ch got %0d want %0d", o_ch, m_ch); end
    if (o_val !== held) begin n_bad++; $display("FAIL nolock_sel_val got %h want %h", o_val, held); end
    // Frozen reload while unlocked is lost
    press(1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 10);
    lock = 1'b1;
    tick(4);
    model_settle();
    n_cmp += 2;
    if (o_val !== held) begin n_bad++; $display("FAIL lost_reload got %h want %h", o_val, held); end
    if (o_ch !== CHW'(m_ch)) begin n_bad++; $display("FAIL lost_reload_ch got %0d want %0d", o_ch, m_ch); end
    press(1'b0, 1'b1, 10);
    n_cmp += 1;
    if (o_val !== probes[m_ch]) begin n_bad++; $display("FAIL relock_val got %h want %h", o_val, probes[m_ch]); end
    $display("txn lock: ch=%0d value=%h", o_ch, o_val);
  endtask

  task automatic test_reset_mid_debounce();
    key_sel_n = 1'b0;
    tick(4);
    rst = 1'b1;
    key_sel_n = 1'b1;
    tick(2);
    rst = 1'b0;
    m_ch = 0; m_frozen = 0;
    n_cmp += 4;
    if (o_val !== 16'h0) begin n_bad++; $display("FAIL midrst_val got %h want 0000", o_val); end
    if (o_hex !== {DIG{7'h40}}) begin n_bad++; $display("FAIL midrst_hex got %h want %h", o_hex, {DIG{7'h40}}); end
    if (o_ch !== 2'd0) begin n_bad++; $display("FAIL midrst_ch got %0d want 0", o_ch); end
    if (o_frz !== 1'b0) begin n_bad++; $display("FAIL midrst_frozen got %b want 0", o_frz); end
    tick(20);
    model_settle();
    n_cmp += 2;
    if (o_ch !== 2'd0) begin n_bad++; $display("FAIL midrst_no_event got %0d want 0", o_ch); end
    if (o_val !== m_value) begin n_bad++; $display("FAIL midrst_track got %h want %h", o_val, m_value); end
    $display("txn reset mid-debounce: ch=%0d value=%h", o_ch, o_val);
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    rst = 1'b1; lock = 1'b1; key_sel_n = 1'b1; key_frz_n = 1'b1;
    for (int c = 0; c < NCH; c++) probes[c] = '0;
    test_reset();
    test_select();
    test_glitch_and_hold();
    test_freeze();
    test_both_keys();
    test_random();
    test_lock();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
